// File: rtl/registerfile_2w2r_sb.sv
// Register file with two write ports, two registered read ports, an optional
// write-to-read bypass and a per-register pending scoreboard.
module registerfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              resetControl_n,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB,
  output logic              pendA,
  output logic              pendB,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [DATA_W-1:0] in0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [DATA_W-1:0] in1,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] pend_rd
);

  // An address is live when it names an implemented register other than a hard zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] outA_q, outA_d, outB_q, outB_d;
  logic              pendA_q, pendA_d, pendB_q, pendB_d;
  logic              we0_ok, we1_ok, sp_ok, rs_ok, rt_ok;

  assign we0_ok = WE0 && addr_ok(rd0);
  assign we1_ok = WE1 && addr_ok(rd1);
  assign sp_ok  = set_pend && addr_ok(pend_rd);
  assign rs_ok  = addr_ok(rs);
  assign rt_ok  = addr_ok(rt);

  // Port 1 is applied after port 0 so it wins a collision; a set beats a clear.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we0_ok && rd0 == ADDR_W'(i)) begin
        regs_d[i] = in0;
        pend_d[i] = 1'b0;
      end
      if (we1_ok && rd1 == ADDR_W'(i)) begin
        regs_d[i] = in1;
        pend_d[i] = 1'b0;
      end
      if (sp_ok && pend_rd == ADDR_W'(i)) pend_d[i] = 1'b1;
    end
  end

  always_comb begin
    outA_d  = outA_q;
    outB_d  = outB_q;
    pendA_d = pendA_q;
    pendB_d = pendB_q;
    if (!stall) begin
      outA_d  = '0;
      outB_d  = '0;
      pendA_d = 1'b0;
      pendB_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rs_ok && rs == ADDR_W'(i)) begin
          outA_d  = (BYPASS != 0) ? regs_d[i] : regs_q[i];
          pendA_d = (BYPASS != 0) ? pend_d[i] : pend_q[i];
        end
        if (rt_ok && rt == ADDR_W'(i)) begin
          outB_d  = (BYPASS != 0) ? regs_d[i] : regs_q[i];
          pendB_d = (BYPASS != 0) ? pend_d[i] : pend_q[i];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge resetControl_n) begin
    if (!resetControl_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q  <= '0;
      outA_q  <= '0;
      outB_q  <= '0;
      pendA_q <= 1'b0;
      pendB_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pend_q  <= pend_d;
      outA_q  <= outA_d;
      outB_q  <= outB_d;
      pendA_q <= pendA_d;
      pendB_q <= pendB_d;
    end
  end

  assign outA  = outA_q;
  assign outB  = outB_q;
  assign pendA = pendA_q;
  assign pendB = pendB_q;

endmodule

// File: tb/tb_registerfile_2w2r_sb.sv
// Bench for registerfile_2w2r_sb: a bypassing and a non-bypassing instance
// (24 registers) driven in parallel and checked against an array model.
module tb_registerfile_2w2r_sb;
  localparam int NR = 24;

  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd0 = '0, rd1 = '0, pend_rd = '0;
  logic [31:0] in0 = '0, in1 = '0;
  logic        WE0 = 1'b0, WE1 = 1'b0, set_pend = 1'b0;
  logic [31:0] outA1, outB1, outA0, outB0;
  logic        pendA1, pendB1, pendA0, pendB0;

  registerfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NR), .ZERO_REG(1), .BYPASS(1)) dut_b1 (
    .Clk(Clk), .resetControl_n(rst_n), .stall(stall), .rs(rs), .rt(rt),
    .outA(outA1), .outB(outB1), .pendA(pendA1), .pendB(pendB1),
    .WE0(WE0), .rd0(rd0), .in0(in0), .WE1(WE1), .rd1(rd1), .in1(in1),
    .set_pend(set_pend), .pend_rd(pend_rd));

  registerfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NR), .ZERO_REG(1), .BYPASS(0)) dut_b0 (
    .Clk(Clk), .resetControl_n(rst_n), .stall(stall), .rs(rs), .rt(rt),
    .outA(outA0), .outB(outB0), .pendA(pendA0), .pendB(pendB0),
    .WE0(WE0), .rd0(rd0), .in0(in0), .WE1(WE1), .rd1(rd1), .in1(in1),
    .set_pend(set_pend), .pend_rd(pend_rd));

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  logic [31:0] e1A, e1B, e0A, e0B;
  bit          e1pA, e1pB, e0pA, e0pB;

  function automatic bit mvalid(input logic [4:0] a);
    return (int'(a) < NR) && (a != 5'd0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end
    e1A = '0; e1B = '0; e0A = '0; e0B = '0;
    e1pA = 0; e1pB = 0; e0pA = 0; e0pB = 0;
  endtask

  // What one rising edge does to the architectural state and the read outputs.
  task automatic model_edge();
    logic [31:0] nreg [32];
    bit          npend [32];
    nreg = m_reg;
    npend = m_pend;
    if (WE0 && mvalid(rd0)) begin nreg[rd0] = in0; npend[rd0] = 0; end
    if (WE1 && mvalid(rd1)) begin nreg[rd1] = in1; npend[rd1] = 0; end
    if (set_pend && mvalid(pend_rd)) npend[pend_rd] = 1;
    if (!stall) begin
      e1A  = mvalid(rs) ? nreg[rs]   : 32'd0;
      e1B  = mvalid(rt) ? nreg[rt]   : 32'd0;
      e1pA = mvalid(rs) ? npend[rs]  : 1'b0;
      e1pB = mvalid(rt) ? npend[rt]  : 1'b0;
      e0A  = mvalid(rs) ? m_reg[rs]  : 32'd0;
      e0B  = mvalid(rt) ? m_reg[rt]  : 32'd0;
      e0pA = mvalid(rs) ? m_pend[rs] : 1'b0;
      e0pB = mvalid(rt) ? m_pend[rt] : 1'b0;
    end
    m_reg = nreg;
    m_pend = npend;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    WE0 = 0; WE1 = 0; set_pend = 0; stall = 0;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_outA1"}, outA1, 0);  cmp({tag, "_outB1"}, outB1, 0);
    cmp({tag, "_pendA1"}, 32'(pendA1), 0); cmp({tag, "_pendB1"}, 32'(pendB1), 0);
    cmp({tag, "_outA0"}, outA0, 0);  cmp({tag, "_pendB0"}, 32'(pendB0), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    #1;
    rst_n = 1;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("outA_b1", outA1, e1A);
      cmp("outB_b1", outB1, e1B);
      cmp("pendA_b1", 32'(pendA1), 32'(e1pA));
      cmp("pendB_b1", 32'(pendB1), 32'(e1pB));
      cmp("outA_b0", outA0, e0A);
      cmp("outB_b0", outB0, e0B);
      cmp("pendA_b0", 32'(pendA0), 32'(e0pA));
      cmp("pendB_b0", 32'(pendB0), 32'(e0pB));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    #1;
    check_all_zero("por");
    rst_n = 1;
    chk_en = 1;

    // Reset discards a stored value.
    WE0 = 1; rd0 = 5; in0 = 32'hDEADBEEF; tick();
    idle(); rs = 5; tick();
    cmp("r5_before_reset", outA1, 32'hDEADBEEF);
    mid_reset();
    tick();
    cmp("r5_after_reset", outA1, 32'h0);

    // Bypass versus plain read.
    WE0 = 1; rd0 = 7; in0 = 32'h11; rs = 7; tick();
    cmp("bypass_b1", outA1, 32'h11);
    cmp("bypass_b0_old", outA0, 32'h0);
    idle(); tick();
    cmp("bypass_b0_new", outA0, 32'h11);

    // Dual-write collision and the hard zero register.
    WE0 = 1; rd0 = 3; in0 = 32'hAA; WE1 = 1; rd1 = 3; in1 = 32'hBB; tick();
    idle(); rs = 3; tick();
    cmp("collision", outA1, 32'hBB);
    WE0 = 1; rd0 = 0; in0 = 32'hFF; tick();
    idle(); rs = 0; tick();
    cmp("zero_reg", outA1, 32'h0);

    // Scoreboard set, set-beats-clear, clear.
    set_pend = 1; pend_rd = 9; rt = 9; tick();
    cmp("pend_set_b1", 32'(pendB1), 1);
    cmp("pend_set_b0", 32'(pendB0), 0);
    idle(); tick();
    cmp("pend_set_b0_late", 32'(pendB0), 1);
    WE0 = 1; rd0 = 9; in0 = 32'h99; set_pend = 1; pend_rd = 9; tick();
    cmp("pend_set_wins", 32'(pendB1), 1);
    idle(); WE1 = 1; rd1 = 9; in1 = 32'h77; tick();
    cmp("pend_clear", 32'(pendB1), 0);
    cmp("pend_clear_data", outB1, 32'h77);
    cmp("pend_clear_b0_old", 32'(pendB0), 1);

    // Stall holds the outputs while state keeps updating.
    idle(); WE0 = 1; rd0 = 6; in0 = 32'h66; rs = 4; tick();
    idle(); stall = 1; rs = 6; WE0 = 1; rd0 = 4; in0 = 32'h55; tick();
    cmp("stall_hold", outA1, 32'h0);
    idle(); tick();
    cmp("stall_release", outA1, 32'h66);
    rs = 4; tick();
    cmp("after_stall", outA1, 32'h55);

    // Out-of-range register.
    rs = 30; tick();
    cmp("oob_read", outA1, 32'h0);
    WE0 = 1; rd0 = 30; in0 = 32'h1; WE1 = 1; rd1 = 24; in1 = 32'h2;
    set_pend = 1; pend_rd = 30; rt = 30; tick();
    cmp("oob_write", outB1, 32'h0);
    cmp("oob_pend", 32'(pendB1), 0);
    idle(); rt = 23; WE0 = 1; rd0 = 23; in0 = 32'h2323; tick();
    cmp("last_reg", outB1, 32'h2323);

    // Randomised traffic with occasional mid-cycle reset.
    idle();
    for (int n = 0; n < 3000; n++) begin
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd0 = 5'($urandom_range(0, 25));
      rd1 = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom_range(0, 25));
      in0 = $urandom;
      in1 = $urandom;
      WE0 = ($urandom_range(0, 1) == 1);
      WE1 = ($urandom_range(0, 1) == 1);
      set_pend = ($urandom_range(0, 2) == 0);
      pend_rd = ($urandom_range(0, 2) == 0) ? rd0 : 5'($urandom_range(0, 25));
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
